// File: rtl/sd_cmd_ctrl.sv
// sd_cmd_ctrl: issues one SD SPI-mode command frame, polls for the R1 response,
// then releases chip select and clocks one trailing byte before reporting completion.
module sd_cmd_ctrl #(
    parameter int unsigned POLL_MAX = 8
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iStart,
    input  logic [5:0]  iCmd,
    input  logic [31:0] iArg,
    input  logic [6:0]  iCrc,
    output logic        oBusy,
    output logic        oDone,
    output logic [7:0]  oResp,
    output logic        oTimeout,
    output logic        oCs,
    output logic        oSpiSend,
    output logic [7:0]  oSpiData,
    input  logic        iSpiTaken,
    input  logic        iSpiAvail,
    input  logic [7:0]  iSpiData
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(5);
    localparam logic [BYTE_W-1:0] POLL_LIMIT = BYTE_W'(POLL_MAX);
    localparam logic [BYTE_W-1:0] FILL_BYTE  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_POLL,
        ST_TAIL
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BYTE_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic                pend_q, pend_d;
    logic [5:0]          cmd_q, cmd_d;
    logic [31:0]         arg_q, arg_d;
    logic [6:0]          crc_q, crc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BYTE_W-1:0]   resp_q, resp_d;
    logic                timeout_q, timeout_d;
    logic                cs_q, cs_d;
    logic                send_q, send_d;
    logic [BYTE_W-1:0]   data_q, data_d;

    logic                taken_c;
    logic                byte_done_c;
    logic [BYTE_W-1:0]   poll_inc_c;

    // Frame byte selected by position within the 6-byte command frame
    function automatic logic [BYTE_W-1:0] frame_byte(
        input logic [IDX_W-1:0] idx,
        input logic [5:0]       cmd,
        input logic [31:0]      arg,
        input logic [6:0]       crc
    );
        case (idx)
            3'd0:    frame_byte = {2'b01, cmd};
            3'd1:    frame_byte = arg[31:24];
            3'd2:    frame_byte = arg[23:16];
            3'd3:    frame_byte = arg[15:8];
            3'd4:    frame_byte = arg[7:0];
            3'd5:    frame_byte = {crc, 1'b1};
            default: frame_byte = FILL_BYTE;
        endcase
    endfunction

    // Handshake qualifiers: a strobe only counts while its byte is outstanding
    assign taken_c     = send_q & iSpiTaken;
    assign byte_done_c = pend_q & iSpiAvail;
    assign poll_inc_c  = poll_cnt_q + 8'd1;

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        poll_cnt_d = poll_cnt_q;
        pend_d     = pend_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        crc_d      = crc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        resp_d     = resp_q;
        timeout_d  = timeout_q;
        cs_d       = cs_q;
        send_d     = send_q;
        data_d     = data_q;

        if (state_q != ST_IDLE && taken_c) begin
            send_d = 1'b0;
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                cs_d   = 1'b1;
                send_d = 1'b0;
                pend_d = 1'b0;
                data_d = FILL_BYTE;
                if (iStart) begin
                    cmd_d      = iCmd;
                    arg_d      = iArg;
                    crc_d      = iCrc;
                    idx_d      = '0;
                    poll_cnt_d = '0;
                    busy_d     = 1'b1;
                    cs_d       = 1'b0;
                    send_d     = 1'b1;
                    data_d     = {2'b01, iCmd};
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                // received bytes are discarded; only the strobe advances the frame
                if (byte_done_c) begin
                    pend_d = 1'b0;
                    send_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        poll_cnt_d = '0;
                        data_d     = FILL_BYTE;
                        state_d    = ST_POLL;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        data_d = frame_byte(idx_q + 3'd1, cmd_q, arg_q, crc_q);
                    end
                end
            end
            ST_POLL: begin
                if (byte_done_c) begin
                    pend_d     = 1'b0;
                    poll_cnt_d = poll_inc_c;
                    if (!iSpiData[7]) begin
                        resp_d    = iSpiData;
                        timeout_d = 1'b0;
                        cs_d      = 1'b1;
                        state_d   = ST_TAIL;
                    end else if (poll_inc_c == POLL_LIMIT) begin
                        resp_d    = FILL_BYTE;
                        timeout_d = 1'b1;
                        cs_d      = 1'b1;
                        state_d   = ST_TAIL;
                    end else begin
                        send_d = 1'b1;
                    end
                end
            end
            ST_TAIL: begin
                // chip select rises first; the trailing byte is requested a cycle later
                if (!send_q && !pend_q) begin
                    send_d = 1'b1;
                    data_d = FILL_BYTE;
                end else if (byte_done_c) begin
                    pend_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            poll_cnt_q <= '0;
            pend_q     <= 1'b0;
            cmd_q      <= '0;
            arg_q      <= '0;
            crc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            resp_q     <= FILL_BYTE;
            timeout_q  <= 1'b0;
            cs_q       <= 1'b1;
            send_q     <= 1'b0;
            data_q     <= FILL_BYTE;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            poll_cnt_q <= poll_cnt_d;
            pend_q     <= pend_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            crc_q      <= crc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            resp_q     <= resp_d;
            timeout_q  <= timeout_d;
            cs_q       <= cs_d;
            send_q     <= send_d;
            data_q     <= data_d;
        end
    end

    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oResp    = resp_q;
    assign oTimeout = timeout_q;
    assign oCs      = cs_q;
    assign oSpiSend = send_q;
    assign oSpiData = data_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// tb_sd_cmd_ctrl: randomized SPI-slave stimulus with a transaction-level reference model.
module tb_sd_cmd_ctrl;

    localparam int POLL_MAX = 8;

    logic        iClk;
    logic        iRstN;
    logic        iStart;
    logic [5:0]  iCmd;
    logic [31:0] iArg;
    logic [6:0]  iCrc;
    logic        oBusy;
    logic        oDone;
    logic [7:0]  oResp;
    logic        oTimeout;
    logic        oCs;
    logic        oSpiSend;
    logic [7:0]  oSpiData;
    logic        iSpiTaken;
    logic        iSpiAvail;
    logic [7:0]  iSpiData;

    sd_cmd_ctrl #(.POLL_MAX(POLL_MAX)) dut (
        .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iCmd(iCmd), .iArg(iArg), .iCrc(iCrc),
        .oBusy(oBusy), .oDone(oDone), .oResp(oResp), .oTimeout(oTimeout), .oCs(oCs),
        .oSpiSend(oSpiSend), .oSpiData(oSpiData), .iSpiTaken(iSpiTaken),
        .iSpiAvail(iSpiAvail), .iSpiData(iSpiData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // reference model: expected byte stream and results per transaction
    bit          in_txn;
    int          pos;
    int          k_poll;
    logic [7:0]  m_resp;
    bit          m_to;
    logic [7:0]  exp_resp;
    bit          exp_to;
    bit          exp_done;
    logic [7:0]  exp_bytes[$];
    logic [7:0]  script[$];

    // slave phase: 0 nothing outstanding, 1 request seen, 2 taken given
    int          ph;
    int          dly;
    int          taken_fix;
    bit          spur_en;

    logic [7:0]  cap[$];
    bit          cap_cs[$];
    int          done_cnt;
    int          n_checks;
    int          n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic void model_start(input logic [5:0] c, input logic [31:0] a, input logic [6:0] r);
        logic [7:0] b;
        exp_bytes.delete();
        exp_bytes.push_back({2'b01, c});
        for (int i = 3; i >= 0; i--) exp_bytes.push_back(a[i*8 +: 8]);
        exp_bytes.push_back({r, 1'b1});
        k_poll = POLL_MAX;
        m_resp = 8'hFF;
        m_to   = 1'b1;
        for (int j = 0; j < POLL_MAX; j++) begin
            b = (j < script.size()) ? script[j] : 8'hFF;
            if (!b[7]) begin
                k_poll = j + 1;
                m_resp = b;
                m_to   = 1'b0;
                break;
            end
        end
        for (int j = 0; j <= k_poll; j++) exp_bytes.push_back(8'hFF);
    endfunction

    function automatic logic [7:0] resp_byte();
        int j;
        j = pos - 6;
        if (j >= 0 && j < k_poll) return (j < script.size()) ? script[j] : 8'hFF;
        return 8'($urandom);
    endfunction

    // apply the rules to what happened at the clock edge just taken
    function automatic void model_edge();
        bit was;
        exp_done = 1'b0;
        if (!iRstN) begin
            in_txn   = 1'b0;
            pos      = 0;
            ph       = 0;
            exp_resp = 8'hFF;
            exp_to   = 1'b0;
        end else begin
            was = in_txn;
            if (was && ph == 2 && iSpiAvail) begin
                pos++;
                ph = 0;
                if (pos == 6 + k_poll) begin
                    exp_resp = m_resp;
                    exp_to   = m_to;
                end
                if (pos == exp_bytes.size()) begin
                    in_txn   = 1'b0;
                    exp_done = 1'b1;
                end
            end else if (ph == 1 && iSpiTaken) begin
                ph  = 2;
                dly = $urandom_range(0, 4);
            end
            if (!was && iStart) begin
                in_txn = 1'b1;
                pos    = 0;
                ph     = 0;
                model_start(iCmd, iArg, iCrc);
            end
        end
    endfunction

    task automatic compare();
        chk("busy", oBusy, in_txn);
        chk("done", oDone, exp_done);
        chk("resp", oResp, exp_resp);
        chk("timeout", oTimeout, exp_to);
        chk("cs", oCs, in_txn ? (pos >= 6 + k_poll) : 1'b1);
        if (ph == 1) chk("send_hold", oSpiSend, 1'b1);
        if (ph == 2) chk("send_drop", oSpiSend, 1'b0);
        if (!in_txn) begin
            chk("send_idle", oSpiSend, 1'b0);
            chk("data_idle", oSpiData, 8'hFF);
        end else if (oSpiSend === 1'b1) begin
            chk($sformatf("data_pos%0d", pos), oSpiData, exp_bytes[pos]);
        end
        if (oDone === 1'b1) done_cnt++;
    endtask

    task automatic slave_react();
        if (ph == 0 && in_txn && oSpiSend === 1'b1) begin
            ph  = 1;
            dly = (taken_fix >= 0) ? taken_fix : $urandom_range(0, 3);
        end
        if (ph == 1) begin
            if (dly == 0) begin
                iSpiTaken = 1'b1;
                cap.push_back(oSpiData);
                cap_cs.push_back(oCs);
            end else dly--;
        end else if (ph == 2) begin
            if (dly == 0) begin
                iSpiAvail = 1'b1;
                iSpiData  = resp_byte();
            end else dly--;
        end else if (spur_en && oSpiSend !== 1'b1 && $urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) iSpiTaken = 1'b1;
            else begin
                iSpiAvail = 1'b1;
                iSpiData  = 8'($urandom_range(0, 127));
            end
        end
    endtask

    task automatic step();
        @(posedge iClk);
        model_edge();
        #1;
        compare();
        iStart    = 1'b0;
        iSpiTaken = 1'b0;
        iSpiAvail = 1'b0;
        slave_react();
    endtask

    task automatic run_txn(input logic [5:0] c, input logic [31:0] a, input logic [6:0] r,
                           input int gap, input bit noise, input bit rst_poll3,
                           output bit ok, output bit got_rst, output logic cs_after);
        int budget;
        for (int i = 0; i < gap; i++) step();
        cap.delete();
        cap_cs.delete();
        done_cnt = 0;
        ok       = 1'b0;
        got_rst  = 1'b0;
        iStart   = 1'b1;
        iCmd     = c;
        iArg     = a;
        iCrc     = r;
        step();
        cs_after = oCs;
        budget   = 0;
        while (budget < 3000) begin
            if (exp_done) begin
                ok = 1'b1;
                break;
            end
            if (rst_poll3 && in_txn && pos == 8 && ph != 0) begin
                iRstN = 1'b0;
                step();
                iRstN   = 1'b1;
                got_rst = 1'b1;
                break;
            end
            if (noise && in_txn && $urandom_range(0, 3) == 0) begin
                iStart = 1'b1;
                iCmd   = 6'($urandom);
                iArg   = $urandom;
                iCrc   = 7'($urandom);
            end
            step();
            budget++;
        end
        if (budget >= 3000) begin
            chk("txn_budget", 32'd0, 32'd1);
            iRstN = 1'b0;
            step();
            iRstN = 1'b1;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        bit         ok;
        bit         got_rst;
        logic       cs_after;
        logic [7:0] cmd0_seq [9];
        logic [7:0] frm_seq  [6];

        n_checks = 0; n_pass = 0; done_cnt = 0;
        iRstN = 1'b0; iStart = 1'b0; iCmd = '0; iArg = '0; iCrc = '0;
        iSpiTaken = 1'b0; iSpiAvail = 1'b0; iSpiData = '0;
        in_txn = 1'b0; pos = 0; ph = 0; dly = 0; k_poll = POLL_MAX;
        exp_resp = 8'hFF; exp_to = 1'b0; exp_done = 1'b0;
        taken_fix = -1; spur_en = 1'b0;

        repeat (3) step();
        chk("rst_cs", oCs, 1'b1);
        chk("rst_send", oSpiSend, 1'b0);
        chk("rst_data", oSpiData, 8'hFF);
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_done", oDone, 1'b0);
        chk("rst_resp", oResp, 8'hFF);
        chk("rst_timeout", oTimeout, 1'b0);
        iRstN = 1'b1;
        repeat (2) step();

        // CMD0 answered after one busy byte
        cmd0_seq = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        script.delete(); script.push_back(8'hFF); script.push_back(8'h01);
        run_txn(6'd0, 32'd0, 7'h4A, 2, 1'b0, 1'b0, ok, got_rst, cs_after);
        chk("cmd0_done", ok, 1'b1);
        chk("cmd0_len", cap.size(), 32'd9);
        if (cap.size() == 9)
            for (int i = 0; i < 9; i++) chk($sformatf("cmd0_byte%0d", i), cap[i], cmd0_seq[i]);
        chk("cmd0_resp", oResp, 8'h01);
        chk("cmd0_timeout", oTimeout, 1'b0);
        repeat (4) step();
        chk("cmd0_done_cnt", done_cnt, 32'd1);

        // no response: poll limit reached
        script.delete();
        run_txn(6'd17, 32'hDEADBEEF, 7'h11, 1, 1'b0, 1'b0, ok, got_rst, cs_after);
        chk("to_done", ok, 1'b1);
        chk("to_len", cap.size(), 32'd15);
        chk("to_resp", oResp, 8'hFF);
        chk("to_timeout", oTimeout, 1'b1);
        if (cap.size() == 15) begin
            chk("to_cs_last_poll", cap_cs[13], 1'b0);
            chk("to_cs_tail", cap_cs[14], 1'b1);
        end

        // start requests while busy must not disturb the frame
        frm_seq = '{8'h51, 8'h12, 8'h34, 8'h56, 8'h78, 8'h55};
        script.delete(); script.push_back(8'hFF); script.push_back(8'hFF); script.push_back(8'h00);
        run_txn(6'd17, 32'h12345678, 7'h2A, 3, 1'b1, 1'b0, ok, got_rst, cs_after);
        chk("noise_done", ok, 1'b1);
        if (cap.size() >= 6)
            for (int i = 0; i < 6; i++) chk($sformatf("noise_byte%0d", i), cap[i], frm_seq[i]);
        chk("noise_resp", oResp, 8'h00);
        chk("noise_timeout", oTimeout, 1'b0);
        repeat (4) step();
        chk("noise_done_cnt", done_cnt, 32'd1);

        // slow SPI master: long wait for the taken strobe
        taken_fix = 20;
        script.delete(); script.push_back(8'h05);
        run_txn(6'd8, 32'h000001AA, 7'h43, 2, 1'b0, 1'b0, ok, got_rst, cs_after);
        taken_fix = -1;
        chk("slow_done", ok, 1'b1);
        chk("slow_resp", oResp, 8'h05);

        // reset during the third poll byte
        script.delete();
        run_txn(6'd55, 32'h0, 7'h32, 2, 1'b0, 1'b1, ok, got_rst, cs_after);
        chk("rstmid_applied", got_rst, 1'b1);
        chk("rstmid_cs", oCs, 1'b1);
        chk("rstmid_send", oSpiSend, 1'b0);
        chk("rstmid_busy", oBusy, 1'b0);
        repeat (10) step();
        chk("rstmid_no_done", done_cnt, 32'd0);

        // back-to-back: next start in the done cycle
        script.delete(); script.push_back(8'h00);
        run_txn(6'd1, 32'h0, 7'h7C, 2, 1'b0, 1'b0, ok, got_rst, cs_after);
        chk("b2b_first_done", ok, 1'b1);
        chk("b2b_in_done_cycle", oDone, 1'b1);
        script.delete(); script.push_back(8'hFF); script.push_back(8'h7E);
        run_txn(6'd9, 32'hCAFEF00D, 7'h01, 0, 1'b0, 1'b0, ok, got_rst, cs_after);
        chk("b2b_cs_next", cs_after, 1'b0);
        chk("b2b_second_done", ok, 1'b1);
        chk("b2b_resp", oResp, 8'h7E);

        // randomized traffic
        spur_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            script.delete();
            for (int j = 0; j < $urandom_range(0, POLL_MAX + 1); j++)
                script.push_back(($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 127))
                                                             : 8'($urandom_range(128, 255)));
            run_txn(6'($urandom), $urandom, 7'($urandom), $urandom_range(0, 3),
                    ($urandom_range(0, 1) == 1), 1'b0, ok, got_rst, cs_after);
            chk($sformatf("rand%0d_done", t), ok, 1'b1);
        end
        spur_en = 1'b0;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
